// File: rtl/ball_motion_controller.sv
// Per-ball motion sequencer: accepts a cue hit, then on each frame pulse integrates
// position, bounces off the table borders, applies friction and publishes the sprite top-left.
module ball_motion_controller #(
  parameter int INIT_X        = 320,
  parameter int INIT_Y        = 240,
  parameter int BORDER_LEFT   = 32,
  parameter int BORDER_RIGHT  = 608,
  parameter int BORDER_TOP    = 32,
  parameter int BORDER_BOTTOM = 448,
  parameter int OBJECT_SIZE   = 16,
  parameter int FRAC_BITS     = 6,
  parameter int FRICTION      = 2,
  parameter int MAX_SPEED     = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               hit_valid,
  input  logic signed [11:0] hit_vx,
  input  logic signed [11:0] hit_vy,
  output logic               hit_ready,
  input  logic               respawn,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               moving,
  output logic               wall_hit
);

  localparam int PW = 11 + FRAC_BITS;
  localparam int SCALE = 2 ** FRAC_BITS;

  localparam logic signed [PW-1:0] X_LO   = PW'(BORDER_LEFT * SCALE);
  localparam logic signed [PW-1:0] X_HI   = PW'((BORDER_RIGHT - OBJECT_SIZE) * SCALE);
  localparam logic signed [PW-1:0] Y_LO   = PW'(BORDER_TOP * SCALE);
  localparam logic signed [PW-1:0] Y_HI   = PW'((BORDER_BOTTOM - OBJECT_SIZE) * SCALE);
  localparam logic signed [PW-1:0] X_INIT = PW'(INIT_X * SCALE);
  localparam logic signed [PW-1:0] Y_INIT = PW'(INIT_Y * SCALE);

  localparam logic signed [11:0] MAX_V  = 12'(MAX_SPEED);
  localparam logic signed [11:0] MIN_V  = 12'(-MAX_SPEED);
  localparam logic signed [11:0] FRIC_P = 12'(FRICTION);
  localparam logic signed [11:0] FRIC_N = 12'(-FRICTION);

  typedef enum logic [2:0] {IDLE, WAIT, S_POS, S_BOUND, S_FRIC} state_t;

  state_t state_q, state_d;

  logic signed [PW-1:0] pos_q [2];
  logic signed [PW-1:0] pos_d [2];
  logic signed [11:0]   vel_q [2];
  logic signed [11:0]   vel_d [2];
  logic signed [10:0]   top_left_x_q, top_left_x_d;
  logic signed [10:0]   top_left_y_q, top_left_y_d;
  logic                 moving_q, moving_d;
  logic                 wall_hit_q, wall_hit_d;

  logic signed [11:0]   hit_v     [2];
  logic signed [11:0]   vel_clamp [2];
  logic signed [PW-1:0] pos_sum   [2];
  logic signed [PW-1:0] pos_bound [2];
  logic signed [11:0]   vel_bound [2];
  logic signed [11:0]   vel_fric  [2];
  logic [1:0]           bounce;
  logic                 hit_accept, hit_nonzero, fric_nonzero;

  assign hit_v[0] = hit_vx;
  assign hit_v[1] = hit_vy;

  // Axis 0 is X, axis 1 is Y; both share identical clamp/integrate/bounce/friction logic.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic signed [PW-1:0] LO = (gi == 0) ? X_LO : Y_LO;
      localparam logic signed [PW-1:0] HI = (gi == 0) ? X_HI : Y_HI;

      assign vel_clamp[gi] = (hit_v[gi] > MAX_V) ? MAX_V :
                             (hit_v[gi] < MIN_V) ? MIN_V : hit_v[gi];
      assign pos_sum[gi]   = pos_q[gi] + {{(PW-12){vel_q[gi][11]}}, vel_q[gi]};
      assign bounce[gi]    = (pos_q[gi] < LO) || (pos_q[gi] > HI);
      assign pos_bound[gi] = (pos_q[gi] < LO) ? LO :
                             (pos_q[gi] > HI) ? HI : pos_q[gi];
      assign vel_bound[gi] = bounce[gi] ? -vel_q[gi] : vel_q[gi];
      assign vel_fric[gi]  = (vel_q[gi] > FRIC_P) ? vel_q[gi] - FRIC_P :
                             (vel_q[gi] < FRIC_N) ? vel_q[gi] + FRIC_P : '0;
    end
  endgenerate

  assign hit_accept   = hit_valid && hit_ready;
  assign hit_nonzero  = (vel_clamp[0] != 12'sd0) || (vel_clamp[1] != 12'sd0);
  assign fric_nonzero = (vel_fric[0] != 12'sd0) || (vel_fric[1] != 12'sd0);

  always_ff @(posedge clk) begin
    if (reset || respawn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit_accept && hit_nonzero) state_d = WAIT;
      WAIT:    if (startOfFrame) state_d = S_POS;
      S_POS:   state_d = S_BOUND;
      S_BOUND: state_d = S_FRIC;
      S_FRIC:  state_d = fric_nonzero ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit_ready = (state_q == IDLE);
  end

  always_comb begin
    pos_d        = pos_q;
    vel_d        = vel_q;
    top_left_x_d = top_left_x_q;
    top_left_y_d = top_left_y_q;
    moving_d     = moving_q;
    wall_hit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_accept) begin
          vel_d    = vel_clamp;
          moving_d = hit_nonzero;
        end
      end
      S_POS:   pos_d = pos_sum;
      S_BOUND: begin
        pos_d      = pos_bound;
        vel_d      = vel_bound;
        wall_hit_d = |bounce;
      end
      S_FRIC: begin
        vel_d        = vel_fric;
        top_left_x_d = pos_q[0][PW-1:FRAC_BITS];
        top_left_y_d = pos_q[1][PW-1:FRAC_BITS];
        moving_d     = fric_nonzero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || respawn) begin
      pos_q[0]     <= X_INIT;
      pos_q[1]     <= Y_INIT;
      vel_q[0]     <= '0;
      vel_q[1]     <= '0;
      top_left_x_q <= 11'(INIT_X);
      top_left_y_q <= 11'(INIT_Y);
      moving_q     <= 1'b0;
      wall_hit_q   <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      vel_q        <= vel_d;
      top_left_x_q <= top_left_x_d;
      top_left_y_q <= top_left_y_d;
      moving_q     <= moving_d;
      wall_hit_q   <= wall_hit_d;
    end
  end

  assign topLeftX = top_left_x_q;
  assign topLeftY = top_left_y_q;
  assign moving   = moving_q;
  assign wall_hit = wall_hit_q;

endmodule

// File: tb/tb_ball_motion_controller.sv
// Bench for ball_motion_controller: table of hit/frame vectors with hand-derived end results,
// a per-frame scoreboard fed by a behavioural model, and hand-written corner sequences.
module tb_ball_motion_controller;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               hit_valid = 1'b0;
  logic signed [11:0] hit_vx = '0;
  logic signed [11:0] hit_vy = '0;
  logic               hit_ready;
  logic               respawn = 1'b0;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               moving;
  logic               wall_hit;

  always #5 clk = ~clk;

  ball_motion_controller dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .hit_valid    (hit_valid),
    .hit_vx       (hit_vx),
    .hit_vy       (hit_vy),
    .hit_ready    (hit_ready),
    .respawn      (respawn),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .moving       (moving),
    .wall_hit     (wall_hit)
  );

  localparam int X_LO = 32 * 64;
  localparam int X_HI = (608 - 16) * 64;
  localparam int Y_LO = 32 * 64;
  localparam int Y_HI = (448 - 16) * 64;

  typedef struct {
    int tlx;
    int tly;
    bit mv;
    bit wh;
  } exp_t;

  typedef struct {
    int vx;
    int vy;
    int frames;
    int tlx;
    int tly;
    bit mv;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_x, m_y, m_vx, m_vy;
  bit m_idle;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > 1023) return 1023;
    if (v < -1023) return -1023;
    return v;
  endfunction

  function automatic int fric(input int v);
    if (v > 2) return v - 2;
    if (v < -2) return v + 2;
    return 0;
  endfunction

  function automatic int to_px(input int p);
    return p >>> 6;
  endfunction

  task automatic model_reset();
    m_x = 320 * 64; m_y = 240 * 64; m_vx = 0; m_vy = 0; m_idle = 1'b1;
  endtask

  task automatic do_respawn();
    @(negedge clk); respawn = 1'b1;
    @(negedge clk); respawn = 1'b0;
    model_reset();
    check("respawn_tlx", topLeftX, 320);
    check("respawn_tly", topLeftY, 240);
    check("respawn_moving", moving, 0);
    check("respawn_ready", hit_ready, 1);
    check("respawn_wall", wall_hit, 0);
    $display("respawn: tl=(%0d,%0d) moving=%0d ready=%0d", topLeftX, topLeftY, moving, hit_ready);
  endtask

  task automatic do_hit(input int vx, input int vy);
    @(negedge clk);
    check("hit_ready_before", hit_ready, int'(m_idle));
    hit_valid = 1'b1; hit_vx = 12'(vx); hit_vy = 12'(vy);
    @(negedge clk);
    hit_valid = 1'b0;
    if (m_idle) begin
      m_vx = clampv(vx); m_vy = clampv(vy);
      if (m_vx != 0 || m_vy != 0) m_idle = 1'b0;
    end
    check("hit_moving", moving, int'(!m_idle));
    check("hit_ready_after", hit_ready, int'(m_idle));
    $display("hit: v=(%0d,%0d) model_v=(%0d,%0d) moving=%0d", vx, vy, m_vx, m_vy, moving);
  endtask

  // Frame pulse sampled at edge n; wall_hit checked after n+2, top-left after n+3.
  task automatic do_frame(output bit wh);
    exp_t e;
    int   prev_x, prev_y;
    prev_x = to_px(m_x); prev_y = to_px(m_y);
    e.wh = 1'b0;
    @(negedge clk); startOfFrame = 1'b1;
    if (!m_idle) begin
      m_x += m_vx; m_y += m_vy;
      if (m_x < X_LO) begin m_x = X_LO; m_vx = -m_vx; e.wh = 1'b1; end
      else if (m_x > X_HI) begin m_x = X_HI; m_vx = -m_vx; e.wh = 1'b1; end
      if (m_y < Y_LO) begin m_y = Y_LO; m_vy = -m_vy; e.wh = 1'b1; end
      else if (m_y > Y_HI) begin m_y = Y_HI; m_vy = -m_vy; e.wh = 1'b1; end
      m_vx = fric(m_vx); m_vy = fric(m_vy);
      if (m_vx == 0 && m_vy == 0) m_idle = 1'b1;
    end
    e.tlx = to_px(m_x); e.tly = to_px(m_y); e.mv = !m_idle;
    sb.push_back(e);
    @(negedge clk); startOfFrame = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("frame_wall_hit", wall_hit, int'(sb[0].wh));
    check("frame_tlx_hold", topLeftX, prev_x);
    @(negedge clk);
    e = sb.pop_front();
    check("frame_tlx", topLeftX, e.tlx);
    check("frame_tly", topLeftY, e.tly);
    check("frame_moving", moving, int'(e.mv));
    check("frame_ready", hit_ready, int'(!e.mv));
    check("frame_wall_clear", wall_hit, 0);
    wh = e.wh;
    $display("frame: tl=(%0d,%0d) exp=(%0d,%0d) moving=%0d wall=%0d", topLeftX, topLeftY, e.tlx, e.tly, moving, e.wh);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    bit   wh;
    int   bounce_frame;

    vt[0] = '{128, 0, 1, 322, 240, 1'b1};
    vt[1] = '{128, 0, 2, 323, 240, 1'b1};
    vt[2] = '{5, -3, 3, 320, 239, 1'b0};
    vt[3] = '{2000, -2047, 1, 335, 224, 1'b1};
    vt[4] = '{0, 0, 1, 320, 240, 1'b0};
    vt[5] = '{-2048, 2047, 1, 304, 255, 1'b1};

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_tlx", topLeftX, 320);
    check("reset_tly", topLeftY, 240);
    check("reset_ready", hit_ready, 1);
    check("reset_moving", moving, 0);
    check("reset_wall", wall_hit, 0);
    $display("reset: tl=(%0d,%0d) ready=%0d moving=%0d", topLeftX, topLeftY, hit_ready, moving);

    // Table-driven vectors with hand-derived final positions
    for (int i = 0; i < 6; i++) begin
      do_respawn();
      do_hit(vt[i].vx, vt[i].vy);
      for (int f = 0; f < vt[i].frames; f++) do_frame(wh);
      check("vec_tlx", topLeftX, vt[i].tlx);
      check("vec_tly", topLeftY, vt[i].tly);
      check("vec_moving", moving, int'(vt[i].mv));
      check("vec_ready", hit_ready, int'(!vt[i].mv));
      $display("vector %0d: tl=(%0d,%0d) exp=(%0d,%0d)", i, topLeftX, topLeftY, vt[i].tlx, vt[i].tly);
    end

    // Left-wall bounce
    do_respawn();
    do_hit(-1023, 0);
    bounce_frame = -1;
    for (int f = 0; f < 40 && bounce_frame < 0; f++) begin
      do_frame(wh);
      if (wh) bounce_frame = f;
    end
    check("bounce_seen", int'(bounce_frame >= 0), 1);
    check("bounce_tlx", topLeftX, 32);
    do_frame(wh);
    check("post_bounce_tlx_gt32", int'(topLeftX > 11'sd32), 1);

    // hit_valid during WAIT is ignored
    do_respawn();
    do_hit(100, 0);
    do_hit(-500, 300);
    do_frame(wh);
    check("wait_hit_ignored_tlx", topLeftX, 321);
    check("wait_hit_ignored_tly", topLeftY, 240);

    // Hit coincident with frame pulse in IDLE: accepted, no motion that frame
    do_respawn();
    @(negedge clk);
    hit_valid = 1'b1; hit_vx = 12'sd64; hit_vy = 12'sd0; startOfFrame = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0; startOfFrame = 1'b0;
    m_vx = 64; m_vy = 0; m_idle = 1'b0;
    repeat (4) @(negedge clk);
    check("coinc_tlx", topLeftX, 320);
    check("coinc_moving", moving, 1);
    check("coinc_ready", hit_ready, 0);
    $display("coincident hit: tl=(%0d,%0d) moving=%0d", topLeftX, topLeftY, moving);
    do_frame(wh);
    check("coinc_next_tlx", topLeftX, 321);

    // Respawn during WAIT after several frames, then frames produce no motion
    do_respawn();
    do_hit(200, 100);
    repeat (3) do_frame(wh);
    do_respawn();
    do_frame(wh);
    check("after_respawn_tlx", topLeftX, 320);
    check("after_respawn_tly", topLeftY, 240);
    check("after_respawn_moving", moving, 0);

    // Reset while in S_BOUND of a bouncing frame: no wall_hit, reset values
    do_respawn();
    do_hit(-1023, 0);
    repeat (18) do_frame(wh);
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    check("midreset_tlx", topLeftX, 320);
    check("midreset_tly", topLeftY, 240);
    check("midreset_wall", wall_hit, 0);
    check("midreset_moving", moving, 0);
    check("midreset_ready", hit_ready, 1);
    @(negedge clk);
    check("midreset_wall_next", wall_hit, 0);
    $display("reset in S_BOUND: tl=(%0d,%0d) wall=%0d", topLeftX, topLeftY, wall_hit);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
